// File: rtl/gen_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gen_share_arbiter
//  Description : Round-robin sharing of one start/ready/valid/done generator
//                between two requesters. Each requester sees a private
//                generator-style port; the arbiter launches the shared
//                instance with the winner's arguments and steers the output
//                stream back to it with zero added latency.
//  Revision    : 1.0  initial release
// ============================================================================
module gen_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                    _clock,
  input  logic                    _reset,

  // requester 0
  input  logic                    r0_start,
  input  logic signed [WIDTH-1:0] r0_base,
  input  logic signed [WIDTH-1:0] r0_limit,
  input  logic signed [WIDTH-1:0] r0_step,
  output logic                    r0_ack,
  input  logic                    r0_ready,
  output logic                    r0_valid,
  output logic                    r0_done,
  output logic signed [WIDTH-1:0] r0_0,
  output logic signed [WIDTH-1:0] r0_1,

  // requester 1
  input  logic                    r1_start,
  input  logic signed [WIDTH-1:0] r1_base,
  input  logic signed [WIDTH-1:0] r1_limit,
  input  logic signed [WIDTH-1:0] r1_step,
  output logic                    r1_ack,
  input  logic                    r1_ready,
  output logic                    r1_valid,
  output logic                    r1_done,
  output logic signed [WIDTH-1:0] r1_0,
  output logic signed [WIDTH-1:0] r1_1,

  // shared generator
  output logic                    g_start,
  output logic                    g_reset,
  output logic signed [WIDTH-1:0] g_base,
  output logic signed [WIDTH-1:0] g_limit,
  output logic signed [WIDTH-1:0] g_step,
  output logic                    g_ready,
  input  logic                    g_valid,
  input  logic                    g_done,
  input  logic signed [WIDTH-1:0] g_0,
  input  logic signed [WIDTH-1:0] g_1
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic [1:0]              state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    prio_q, prio_d;
  logic                    g_start_q, g_start_d;
  logic                    r0_ack_q, r0_ack_d;
  logic                    r1_ack_q, r1_ack_d;
  logic                    r0_done_q, r0_done_d;
  logic                    r1_done_q, r1_done_d;
  logic signed [WIDTH-1:0] base_q, base_d;
  logic signed [WIDTH-1:0] limit_q, limit_d;
  logic signed [WIDTH-1:0] step_q, step_d;

  // Last tuple each requester saw; shown whenever it is not the streaming owner.
  logic signed [WIDTH-1:0] r0_hold0_q, r0_hold1_q;
  logic signed [WIDTH-1:0] r1_hold0_q, r1_hold1_q;

  logic w_streaming;
  logic w_pass0;
  logic w_pass1;
  logic w_own_ready;
  logic w_end_of_call;
  logic w_cooldown;
  logic w_any_req;
  logic w_winner;

  assign w_streaming = (state_q == ST_STREAM);
  assign w_pass0     = w_streaming && !owner_q;
  assign w_pass1     = w_streaming &&  owner_q;
  assign w_own_ready = owner_q ? r1_ready : r0_ready;

  // A call ends once the generator reports done with no beat still waiting
  // to be taken by the owner.
  assign w_end_of_call = w_streaming && g_done && !(g_valid && !g_ready);

  // The cycle a done pulse is out, no new launch is decided; this keeps the
  // next g_start at least two cycles behind the done pulse.
  assign w_cooldown = r0_done_q || r1_done_q;

  assign w_any_req = r0_start || r1_start;
  // Contention goes to the priority pointer; otherwise the sole requester.
  assign w_winner  = (r0_start && r1_start) ? prio_q : r1_start;

  // Generator-side outputs.
  assign g_reset = _reset;
  assign g_start = g_start_q;
  assign g_base  = base_q;
  assign g_limit = limit_q;
  assign g_step  = step_q;
  assign g_ready = w_streaming && w_own_ready;

  // Requester-side outputs: owner gets the live stream, others hold.
  assign r0_ack   = r0_ack_q;
  assign r1_ack   = r1_ack_q;
  assign r0_done  = r0_done_q;
  assign r1_done  = r1_done_q;
  assign r0_valid = w_pass0 && g_valid;
  assign r1_valid = w_pass1 && g_valid;
  assign r0_0     = w_pass0 ? g_0 : r0_hold0_q;
  assign r0_1     = w_pass0 ? g_1 : r0_hold1_q;
  assign r1_0     = w_pass1 ? g_0 : r1_hold0_q;
  assign r1_1     = w_pass1 ? g_1 : r1_hold1_q;

  // Next-state logic: grant in IDLE, one launch cycle, then stream to done.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    prio_d    = prio_q;
    g_start_d = 1'b0;
    r0_ack_d  = 1'b0;
    r1_ack_d  = 1'b0;
    r0_done_d = 1'b0;
    r1_done_d = 1'b0;
    base_d    = base_q;
    limit_d   = limit_q;
    step_d    = step_q;

    case (state_q)
      ST_IDLE: begin
        if (w_any_req && !w_cooldown) begin
          owner_d   = w_winner;
          base_d    = w_winner ? r1_base  : r0_base;
          limit_d   = w_winner ? r1_limit : r0_limit;
          step_d    = w_winner ? r1_step  : r0_step;
          g_start_d = 1'b1;
          r0_ack_d  = !w_winner;
          r1_ack_d  =  w_winner;
          state_d   = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        state_d = ST_STREAM;
      end

      ST_STREAM: begin
        if (w_end_of_call) begin
          r0_done_d = !owner_q;
          r1_done_d =  owner_q;
          prio_d    = !owner_q;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and argument registers.
  always_ff @(posedge _clock) begin
    if (_reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      prio_q    <= 1'b0;
      g_start_q <= 1'b0;
      r0_ack_q  <= 1'b0;
      r1_ack_q  <= 1'b0;
      r0_done_q <= 1'b0;
      r1_done_q <= 1'b0;
      base_q    <= '0;
      limit_q   <= '0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      prio_q    <= prio_d;
      g_start_q <= g_start_d;
      r0_ack_q  <= r0_ack_d;
      r1_ack_q  <= r1_ack_d;
      r0_done_q <= r0_done_d;
      r1_done_q <= r1_done_d;
      base_q    <= base_d;
      limit_q   <= limit_d;
      step_q    <= step_d;
    end
  end

  // Track what each requester last saw so its outputs freeze when not owner.
  always_ff @(posedge _clock) begin
    if (_reset) begin
      r0_hold0_q <= '0;
      r0_hold1_q <= '0;
      r1_hold0_q <= '0;
      r1_hold1_q <= '0;
    end else begin
      if (w_pass0) begin
        r0_hold0_q <= g_0;
        r0_hold1_q <= g_1;
      end
      if (w_pass1) begin
        r1_hold0_q <= g_0;
        r1_hold1_q <= g_1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gen_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gen_share_arbiter
//  Description : Self-checking bench for gen_share_arbiter with a behavioural
//                range generator, directed calls and randomized traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gen_share_arbiter;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]         r_start = 2'b00;
  logic [1:0]         r_ready = 2'b11;
  logic signed [W-1:0] r_base  [2];
  logic signed [W-1:0] r_limit [2];
  logic signed [W-1:0] r_step  [2];
  wire  [1:0]         r_ack, r_valid, r_done;
  wire  signed [W-1:0] r0_0w, r0_1w, r1_0w, r1_1w;

  wire                g_start, g_reset, g_ready;
  wire  signed [W-1:0] g_base, g_limit, g_step;
  wire                g_valid, g_done;
  wire  signed [W-1:0] g_0, g_1;

  gen_share_arbiter #(.WIDTH(W)) dut (
    ._clock   (clk),
    ._reset   (rst),
    .r0_start (r_start[0]),
    .r0_base  (r_base[0]),
    .r0_limit (r_limit[0]),
    .r0_step  (r_step[0]),
    .r0_ack   (r_ack[0]),
    .r0_ready (r_ready[0]),
    .r0_valid (r_valid[0]),
    .r0_done  (r_done[0]),
    .r0_0     (r0_0w),
    .r0_1     (r0_1w),
    .r1_start (r_start[1]),
    .r1_base  (r_base[1]),
    .r1_limit (r_limit[1]),
    .r1_step  (r_step[1]),
    .r1_ack   (r_ack[1]),
    .r1_ready (r_ready[1]),
    .r1_valid (r_valid[1]),
    .r1_done  (r_done[1]),
    .r1_0     (r1_0w),
    .r1_1     (r1_1w),
    .g_start  (g_start),
    .g_reset  (g_reset),
    .g_base   (g_base),
    .g_limit  (g_limit),
    .g_step   (g_step),
    .g_ready  (g_ready),
    .g_valid  (g_valid),
    .g_done   (g_done),
    .g_0      (g_0),
    .g_1      (g_1)
  );

  // ---------------- behavioural range generator ----------------
  int   off      = 0;    // g_1 = g_0 + off, distinguishes the two tuple fields
  logic gen_rand = 1'b0; // insert random bubbles between beats
  logic gact = 1'b0, bubble = 1'b0;
  int   gcur = 0, glim = 0, gstep = 0;

  assign g_valid = gact && (gcur < glim) && !bubble;
  assign g_done  = gact && !(gcur < glim);
  assign g_0     = gcur;
  assign g_1     = gcur + off;

  always @(posedge clk) begin
    if (g_reset) begin
      gact   <= 1'b0;
      bubble <= 1'b0;
    end else begin
      if (g_start) begin
        gact  <= 1'b1;
        gcur  <= g_base;
        glim  <= g_limit;
        gstep <= g_step;
      end else if (gact) begin
        if (g_done)                gact <= 1'b0;
        else if (g_valid && g_ready) gcur <= gcur + gstep;
      end
      bubble <= (g_valid && !g_ready) ? 1'b0 : (gen_rand && ($urandom_range(0, 3) == 0));
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nbeats(input int b, input int l, input int s);
    int c = 0;
    for (longint v = b; v < l; v += s) c++;
    return c;
  endfunction

  function automatic longint o0(input int n);
    return (n == 1) ? longint'(r1_0w) : longint'(r0_0w);
  endfunction
  function automatic longint o1(input int n);
    return (n == 1) ? longint'(r1_1w) : longint'(r0_1w);
  endfunction

  // ---------------- reference model state ----------------
  int   expq0[$];
  int   expq1[$];
  int   grant_q[$];
  logic [1:0] busy = 2'b00;
  logic [1:0] prev_busy = 2'b00;
  logic [1:0] prev_stall = 2'b00;
  logic [1:0] prev_start = 2'b00;
  logic prev_rst = 1'b1;
  int   ptr_m = 0;
  int   acc_cnt [2] = '{0, 0};
  int   done_cnt[2] = '{0, 0};
  int   ack_cnt = 0, abort_cnt = 0;
  longint prev_o0[2], prev_o1[2];

  function automatic int qsize(input int n);
    return (n == 1) ? expq1.size() : expq0.size();
  endfunction

  // Monitor: every cycle, compare DUT outputs against the rules of the block.
  initial begin
    forever begin
      @(negedge clk);
      check("g_reset_follows", g_reset, rst);
      if (rst) begin
        abort_cnt += int'(busy[0]) + int'(busy[1]);
        busy = 2'b00;
        expq0.delete();
        expq1.delete();
        ptr_m = 0;
        prev_stall = 2'b00;
      end else begin
        if (prev_rst) begin
          check("rst_ack", r_ack, 0);
          check("rst_done", r_done, 0);
          check("rst_gstart", g_start, 0);
          check("rst_gbase", g_base, 0);
          check("rst_glimit", g_limit, 0);
          check("rst_gstep", g_step, 0);
          check("rst_valid", r_valid, 0);
          check("rst_gready", g_ready, 0);
        end
        check("gstart_with_ack", g_start, (r_ack != 2'b00));
        for (int n = 0; n < 2; n++) begin
          if (r_done[n]) begin
            check("done_for_launched", busy[n], 1);
            check("done_beats_left", qsize(n), 0);
            busy[n] = 1'b0;
            done_cnt[n]++;
            ptr_m = 1 - n;
          end
        end
        for (int n = 0; n < 2; n++) begin
          if (r_ack[n]) begin
            int w;
            check("ack_while_busy", busy, 0);
            case (prev_start)
              2'b11:   w = ptr_m;
              2'b01:   w = 0;
              2'b10:   w = 1;
              default: w = -1;
            endcase
            check("ack_winner", n, w);
            check("ack_no_valid", r_valid[n], 0);
            for (longint v = r_base[n]; v < r_limit[n]; v += r_step[n]) begin
              if (n == 0) expq0.push_back(int'(v));
              else        expq1.push_back(int'(v));
            end
            busy[n] = 1'b1;
            ack_cnt++;
            grant_q.push_back(n);
          end
        end
        for (int n = 0; n < 2; n++) begin
          if (!busy[n]) check("idle_valid", r_valid[n], 0);
          if (!busy[n] && !prev_busy[n] && !prev_rst) begin
            check("idle_hold_0", o0(n), prev_o0[n]);
            check("idle_hold_1", o1(n), prev_o1[n]);
          end
          if (prev_stall[n]) begin
            check("stall_valid_held", r_valid[n], 1);
            check("stall_data_held", o0(n), prev_o0[n]);
          end
          if (r_valid[n] && r_ready[n]) begin
            if (qsize(n) == 0) begin
              check("beat_unexpected", 1, 0);
            end else begin
              int v;
              v = (n == 0) ? expq0.pop_front() : expq1.pop_front();
              check("beat_0", o0(n), v);
              check("beat_1", o1(n), longint'(v) + off);
              acc_cnt[n]++;
            end
          end
        end
        if (r_ack == 2'b00 && busy[0])      check("g_ready_mirror", g_ready, r_ready[0]);
        else if (r_ack == 2'b00 && busy[1]) check("g_ready_mirror", g_ready, r_ready[1]);
        else                                check("g_ready_idle", g_ready, 0);
        prev_stall = r_valid & ~r_ready;
      end
      prev_rst   = rst;
      prev_busy  = busy;
      prev_start = r_start;
      for (int n = 0; n < 2; n++) begin
        prev_o0[n] = o0(n);
        prev_o1[n] = o1(n);
      end
    end
  end

  // ---------------- ready driver ----------------
  int rdy_mode = 0; // 0: always ready, 1: r0 pattern 1,0,0,1, 2: random
  initial begin
    int idx = 0;
    logic [3:0] pat = 4'b1001;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1: begin r_ready[0] = pat[3 - (idx % 4)]; r_ready[1] = 1'b1; idx++; end
        2: begin r_ready[0] = ($urandom_range(0, 3) != 0); r_ready[1] = ($urandom_range(0, 3) != 0); end
        default: begin r_ready = 2'b11; idx = 0; end
      endcase
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_call(input int n, input int b, input int l, input int s);
    int cyc, a0, d0;
    a0 = acc_cnt[n];
    d0 = done_cnt[n];
    @(posedge clk); #1;
    r_base[n] = b; r_limit[n] = l; r_step[n] = s; r_start[n] = 1'b1;
    @(negedge clk); #1;
    cyc = 0;
    while (!r_ack[n] && cyc < 20) begin @(negedge clk); #1; cyc++; end
    check("ack_latency", cyc, 1);
    @(posedge clk); #1;
    r_start[n] = 1'b0;
    cyc = 0;
    while (done_cnt[n] == d0 && cyc < 500) begin @(negedge clk); #1; cyc++; end
    check("done_pulses", done_cnt[n] - d0, 1);
    check("beat_count", acc_cnt[n] - a0, nbeats(b, l, s));
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_grants(input int k);
    int cyc = 0;
    while (grant_q.size() < k && cyc < 2000) begin @(negedge clk); #1; cyc++; end
    if (grant_q.size() < k) check("grant_timeout", grant_q.size(), k);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (busy != 2'b00 && cyc < 2000) begin @(negedge clk); #1; cyc++; end
    check("idle_reached", busy, 0);
    repeat (3) @(posedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a0, d0, cyc;
    int gap[2];
    for (int n = 0; n < 2; n++) begin r_base[n] = 0; r_limit[n] = 0; r_step[n] = 1; gap[n] = 0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // single call on requester 0
    do_call(0, 0, 10, 2);

    // simultaneous calls right after a reset: r0 first, then r1
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    grant_q.delete();
    @(posedge clk); #1;
    r_base[0] = 0;  r_limit[0] = 6;  r_step[0] = 2;
    r_base[1] = 10; r_limit[1] = 13; r_step[1] = 1;
    r_start = 2'b11;
    wait_grants(1);
    @(posedge clk); #1 r_start[0] = 1'b0;
    wait_grants(2);
    @(posedge clk); #1 r_start[1] = 1'b0;
    wait_idle();
    check("simul_grants", grant_q.size(), 2);
    if (grant_q.size() == 2) begin
      check("simul_first", grant_q[0], 0);
      check("simul_second", grant_q[1], 1);
    end

    // backpressure on r0
    rdy_mode = 1;
    do_call(0, 0, 10, 3);
    rdy_mode = 0;

    // empty range on r1
    do_call(1, 5, 5, 1);

    // reset in the middle of an r0 stream
    a0 = acc_cnt[0];
    d0 = done_cnt[0];
    @(posedge clk); #1;
    r_base[0] = 0; r_limit[0] = 10; r_step[0] = 2; r_start[0] = 1'b1;
    cyc = 0;
    while (acc_cnt[0] < a0 + 2 && cyc < 100) begin
      @(negedge clk); #1; cyc++;
      if (r_ack[0]) begin @(posedge clk); #1 r_start[0] = 1'b0; end
    end
    check("pre_reset_beats", acc_cnt[0] - a0, 2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    check("abort_no_done", done_cnt[0] - d0, 0);
    do_call(1, 0, 2, 1);

    // fairness with both requests held high
    grant_q.delete();
    @(posedge clk); #1;
    r_base[0] = 0;   r_limit[0] = 4;   r_step[0] = 1;
    r_base[1] = 100; r_limit[1] = 103; r_step[1] = 1;
    r_start = 2'b11;
    wait_grants(4);
    @(posedge clk); #1 r_start = 2'b00;
    wait_idle();
    check("fair_grants", grant_q.size(), 4);
    if (grant_q.size() == 4)
      for (int i = 0; i < 4; i++) check("fair_order", grant_q[i], i % 2);

    // randomized traffic
    off = 5;
    gen_rand = 1'b1;
    rdy_mode = 2;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
        if (r_start[n] && r_ack[n]) begin
          r_start[n] = 1'b0;
          gap[n] = $urandom_range(0, 5);
        end else if (r_start[n] && $urandom_range(0, 30) == 0) begin
          r_start[n] = 1'b0;
          gap[n] = $urandom_range(0, 5);
        end else if (!r_start[n] && !busy[n] && !r_ack[n]) begin
          if (gap[n] > 0) gap[n]--;
          else begin
            r_base[n]  = $signed($urandom_range(0, 40)) - 20;
            r_step[n]  = $urandom_range(1, 4);
            r_limit[n] = r_base[n] + $signed($urandom_range(0, 12));
            r_start[n] = 1'b1;
          end
        end
      end
    end
    r_start = 2'b00;
    wait_idle();
    rdy_mode = 0;
    gen_rand = 1'b0;
    check("calls_balanced", done_cnt[0] + done_cnt[1] + abort_cnt, ack_cnt);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
